// File: rtl/alu_sched.sv
// alu_sched: shares one combinational ALU between two requesters, one operation at a time.
// Define ALU_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_sched #(
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [2:0]    req0_op,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [2:0]    req1_op,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic [2:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    input  logic          rsp_ready,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t        r_state;
    logic [2:0]    r_aluOp;
    logic [DW-1:0] r_aluA;
    logic [DW-1:0] r_aluB;
    logic          r_rspValid;
    logic          r_rspId;
    logic [DW-1:0] r_rspData;
    logic          r_busy;

    logic          w_winner;
    logic          w_grantOpen;
    logic          w_accept;

`ifdef ALU_SCHED_RR_EN
    logic          r_rrPtr;

    // The pointer only breaks ties; a lone valid requester always wins.
    always_comb begin
        w_winner = 1'b0;
        if (req0_valid && req1_valid)
            w_winner = r_rrPtr;
        else if (req1_valid)
            w_winner = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            r_rrPtr <= 1'b0;
        else if (r_state == RESP && rsp_ready)
            r_rrPtr <= ~r_rspId;
    end
`else
    assign w_winner = ~req0_valid;
`endif

    assign w_grantOpen = (r_state == IDLE) && !Reset;
    assign req0_ready  = w_grantOpen && req0_valid && !w_winner;
    assign req1_ready  = w_grantOpen && req1_valid && w_winner;
    assign w_accept    = req0_ready || req1_ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_aluOp    <= 3'b000;
            r_aluA     <= '0;
            r_aluB     <= '0;
            r_rspValid <= 1'b0;
            r_rspId    <= 1'b0;
            r_rspData  <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_aluOp <= w_winner ? req1_op : req0_op;
                        r_aluA  <= w_winner ? req1_a  : req0_a;
                        r_aluB  <= w_winner ? req1_b  : req0_b;
                        r_rspId <= w_winner;
                        r_busy  <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rspData  <= alu_result;
                    r_rspValid <= 1'b1;
                    r_state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_rspValid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign alu_op    = r_aluOp;
    assign alu_a     = r_aluA;
    assign alu_b     = r_aluB;
    assign rsp_valid = r_rspValid;
    assign rsp_id    = r_rspId;
    assign rsp_data  = r_rspData;
    assign busy      = r_busy;

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed bench for alu_sched with a transaction-level reference model.
// Honours ALU_SCHED_RR_EN the same way the design does.
module tb_alu_sched;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [2:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_result;
    logic       rsp_valid, rsp_id, rsp_ready, busy;
    logic [7:0] rsp_data;

    int vecCnt  = 0;
    int missCnt = 0;
    int edgeCnt = 0;
    int dutGrants[$];

    // Reference model state: one operation in flight, aged in clock edges since acceptance.
    logic       mInflight = 1'b0;
    int         mAge      = 0;
    logic       mId       = 1'b0;
    logic [2:0] mOp       = 3'b000;
    logic [7:0] mA        = 8'h00;
    logic [7:0] mB        = 8'h00;
    logic [7:0] mData     = 8'h00;
    logic       mPtr      = 1'b0;

    always #5 Clk = ~Clk;

    alu_sched #(.DW(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    function automatic logic [7:0] aluFn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b000:  return a ^ b;
            3'b001:  return a + b;
            3'b010:  return a - b;
            3'b011:  return a;
            3'b100:  return a & b;
            3'b101:  return a | b;
            3'b110:  return a << b[2:0];
            default: return b;
        endcase
    endfunction

    assign alu_result = aluFn(alu_op, alu_a, alu_b);

    function automatic logic pickWinner(input logic v0, input logic v1, input logic ptr);
        if (v0 && v1) begin
`ifdef ALU_SCHED_RR_EN
            return ptr;
`else
            return 1'b0;
`endif
        end
        return v1 && !v0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCnt++;
        if (actual !== expected) begin
            missCnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [2:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                                 input logic v1, input logic [2:0] op1, input logic [7:0] a1, input logic [7:0] b1);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic dropValids();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("drainTimeout", {31'd0, busy}, 32'd0);
    endtask

    // Model update: acceptance, result capture one edge later, completion on handshake.
    always @(posedge Clk) begin
        logic w;
        edgeCnt++;
        if (Reset) begin
            mInflight = 1'b0; mAge = 0; mId = 1'b0;
            mOp = 3'b000; mA = 8'h00; mB = 8'h00; mData = 8'h00; mPtr = 1'b0;
        end else if (!mInflight) begin
            if (req0_valid || req1_valid) begin
                w = pickWinner(req0_valid, req1_valid, mPtr);
                mInflight = 1'b1;
                mAge = 0;
                mId = w;
                mOp = w ? req1_op : req0_op;
                mA  = w ? req1_a  : req0_a;
                mB  = w ? req1_b  : req0_b;
            end
        end else if (mAge == 0) begin
            mAge = 1;
            mData = aluFn(mOp, mA, mB);
        end else if (rsp_ready) begin
            mInflight = 1'b0;
            mPtr = !mId;
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge Clk) begin
        logic w;
        if (edgeCnt > 0) begin
            w = pickWinner(req0_valid, req1_valid, mPtr);
            checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, !Reset && !mInflight && req0_valid && !w});
            checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, !Reset && !mInflight && req1_valid && w});
            checkOutput("busy",      {31'd0, busy},      {31'd0, mInflight});
            checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, mInflight && mAge >= 1});
            checkOutput("rsp_id",    {31'd0, rsp_id},    {31'd0, mId});
            checkOutput("rsp_data",  {24'd0, rsp_data},  {24'd0, mData});
            checkOutput("alu_op",    {29'd0, alu_op},    {29'd0, mOp});
            checkOutput("alu_a",     {24'd0, alu_a},     {24'd0, mA});
            checkOutput("alu_b",     {24'd0, alu_b},     {24'd0, mB});
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1)
                dutGrants.push_back(int'(rsp_id));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL globalTimeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int expG[4];
        logic [7:0] av, bv;
`ifdef ALU_SCHED_RR_EN
        expG = '{0, 1, 0, 1};
`else
        expG = '{0, 0, 0, 0};
`endif
        // Reset with a valid request pending: nothing may be granted or accepted.
        Reset = 1'b1;
        rsp_ready = 1'b0;
        applyStimulus(1'b1, 3'b001, 8'h05, 8'h03, 1'b0, 3'b000, 8'h00, 8'h00);
        tick();
        tick();
        checkOutput("rstReady0", {31'd0, req0_ready}, 32'd0);
        checkOutput("rstBusy",   {31'd0, busy}, 32'd0);
        checkOutput("rstAluOp",  {29'd0, alu_op}, 32'd0);
        checkOutput("rstData",   {24'd0, rsp_data}, 32'd0);

        // Single ADD from requester 0.
        Reset = 1'b0;
        #1;
        checkOutput("addReady0", {31'd0, req0_ready}, 32'd1);
        tick();
        dropValids();
        checkOutput("addExecValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("addAluA",      {24'd0, alu_a}, 32'h05);
        tick();
        checkOutput("addRspValid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("addRspData",  {24'd0, rsp_data}, 32'h08);
        checkOutput("addRspId",    {31'd0, rsp_id}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        checkOutput("addDoneBusy", {31'd0, busy}, 32'd0);

        // Contention from a fresh pointer.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        dutGrants.delete();
        applyStimulus(1'b1, 3'b001, 8'h01, 8'h01, 1'b1, 3'b001, 8'h02, 8'h02);
        repeat (12) tick();
        dropValids();
        drain();
        checkOutput("grantCount", dutGrants.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("grant%0d", i), (i < dutGrants.size()) ? dutGrants[i] : 32'hDEAD, expG[i]);

        // Backpressure on a requester-1 SUB while requester 0 waits.
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 1'b1, 3'b010, 8'h00, 8'h01);
        tick();
        applyStimulus(1'b1, 3'b100, 8'hF0, 8'h3C, 1'b0, 3'b000, 8'h00, 8'h00);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bpValid",  {31'd0, rsp_valid}, 32'd1);
            checkOutput("bpData",   {24'd0, rsp_data}, 32'hFF);
            checkOutput("bpId",     {31'd0, rsp_id}, 32'd1);
            checkOutput("bpReady0", {31'd0, req0_ready}, 32'd0);
            checkOutput("bpBusy",   {31'd0, busy}, 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checkOutput("bpIdleBusy",   {31'd0, busy}, 32'd0);
        checkOutput("bpIdleReady0", {31'd0, req0_ready}, 32'd1);
        tick();
        dropValids();
        drain();

        // Reset while in RESP discards the held response.
        applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 1'b1, 3'b011, 8'h77, 8'h00);
        tick();
        dropValids();
        rsp_ready = 1'b0;
        tick();
        checkOutput("respId", {31'd0, rsp_id}, 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        rsp_ready = 1'b1;
        checkOutput("rstRespValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rstRespId",    {31'd0, rsp_id}, 32'd0);

        // Reset during EXEC of an XOR.
        applyStimulus(1'b1, 3'b000, 8'hAA, 8'h55, 1'b0, 3'b000, 8'h00, 8'h00);
        tick();
        dropValids();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkOutput("rstExecValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rstExecData",  {24'd0, rsp_data}, 32'd0);
        checkOutput("rstExecAluOp", {29'd0, alu_op}, 32'd0);
        checkOutput("rstExecAluA",  {24'd0, alu_a}, 32'd0);
        checkOutput("rstExecAluB",  {24'd0, alu_b}, 32'd0);
        checkOutput("rstExecBusy",  {31'd0, busy}, 32'd0);
        repeat (4) begin
            tick();
            checkOutput("rstExecNoRsp", {31'd0, rsp_valid}, 32'd0);
        end

        // Every opcode, alternating requesters.
        for (int i = 0; i < 8; i++) begin
            av = 8'(8'hC3 + i * 29);
            bv = 8'(i * 3 + 1);
            if (i % 2 == 0)
                applyStimulus(1'b1, 3'(i), av, bv, 1'b0, 3'b000, 8'h00, 8'h00);
            else
                applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 1'b1, 3'(i), av, bv);
            tick();
            dropValids();
            drain();
        end

        // MOVI, then a long idle with rsp_ready held high.
        applyStimulus(1'b1, 3'b111, 8'h12, 8'h34, 1'b0, 3'b000, 8'h00, 8'h00);
        tick();
        dropValids();
        tick();
        checkOutput("moviData", {24'd0, rsp_data}, 32'h34);
        drain();
        repeat (10) begin
            checkOutput("idleAluOp",  {29'd0, alu_op}, 32'd7);
            checkOutput("idleAluA",   {24'd0, alu_a}, 32'h12);
            checkOutput("idleAluB",   {24'd0, alu_b}, 32'h34);
            checkOutput("idleReady1", {31'd0, req1_ready}, 32'd0);
            checkOutput("idleBusy",   {31'd0, busy}, 32'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
